// File: rtl/mbuf_pkg.sv
// mbuf_pkg: shared sizing helpers and default dimensions for the mbuf pipeline
package mbuf_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 2;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic inv_parity(input logic [31:0] mask);
        return ^mask;
    endfunction
endpackage

// File: rtl/mbuf_stage.sv
// mbuf_stage: one elastic register slot that optionally inverts the word it captures
module mbuf_stage
    import mbuf_pkg::*;
#(
    parameter int   WIDTH = DEF_WIDTH,
    parameter logic INV   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             up_ready,
    output logic             dn_valid,
    output logic [WIDTH-1:0] dn_data,
    input  logic             dn_ready
);
    assign up_ready = !dn_valid | dn_ready;

    // flush drops the valid bit only; the data register keeps its last word
    always_ff @(posedge clk) begin
        if (reset) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
        end else if (flush) begin
            dn_valid <= 1'b0;
        end else if (up_ready) begin
            dn_valid <= up_valid;
            if (up_valid) dn_data <= up_data ^ {WIDTH{INV}};
        end
    end
endmodule

// File: rtl/mbuf_pipe.sv
// mbuf_pipe: DEPTH-stage elastic register pipeline with valid/ready handshakes,
// per-stage inversion, synchronous flush and occupancy reporting
module mbuf_pipe
    import mbuf_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter int               DEPTH    = DEF_DEPTH,
    parameter logic [DEPTH-1:0] INV_MASK = {DEPTH{1'b1}}
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    output logic [occ_width(DEPTH)-1:0]  occupancy
);
    localparam int OW = occ_width(DEPTH);

    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0]            up_rdy;
    logic [DEPTH-1:0]            dn_rdy;
    logic [DEPTH-1:0][WIDTH-1:0] d;
    logic                        push;

    // stage k may advance when the exit is open or any stage downstream of it is empty;
    // computed from the valid bits directly so no combinational chain runs through the stages
    always_comb begin
        dn_rdy = '0;
        for (int k = 0; k < DEPTH; k++) dn_rdy[k] = out_ready | (|(~v >> (k + 1)));
    end

    // any ready stage implies stage 0 is ready, so the OR equals the head's ready
    assign in_ready  = (|up_rdy) & !flush & !reset;
    assign push      = in_valid & in_ready;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) occupancy = occupancy + OW'(v[k]);
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             up_v;
        logic [WIDTH-1:0] up_d;
        if (k == 0) begin : g_head
            assign up_v = push;
            assign up_d = in_data;
        end else begin : g_tail
            assign up_v = v[k-1];
            assign up_d = d[k-1];
        end
        mbuf_stage #(
            .WIDTH(WIDTH),
            .INV  (INV_MASK[k])
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .flush   (flush),
            .up_valid(up_v),
            .up_data (up_d),
            .up_ready(up_rdy[k]),
            .dn_valid(v[k]),
            .dn_data (d[k]),
            .dn_ready(dn_rdy[k])
        );
    end
endmodule

// File: tb/tb_mbuf_pipe.sv
// tb_mbuf_pipe: three pipeline configurations driven in lockstep, checked every cycle
// against a slot-queue model plus directed literal expectations
module tb_mbuf_pipe;
    import mbuf_pkg::*;

    localparam logic [1:0] MA = 2'b11;
    localparam logic [1:0] MB = 2'b01;
    localparam logic [3:0] MC = 4'b1011;
    localparam logic [2:0] PAR = {inv_parity(32'(MC)), inv_parity(32'(MB)), inv_parity(32'(MA))};

    logic clk = 1'b0;
    logic reset, flush, in_valid, out_ready;
    logic [15:0] in_data;
    always #5 clk = ~clk;

    logic a_rdy, a_ov, b_rdy, b_ov, c_rdy, c_ov;
    logic [7:0] a_od, b_od;
    logic [15:0] c_od;
    logic [1:0] a_occ, b_occ;
    logic [2:0] c_occ;

    mbuf_pipe #(.WIDTH(8), .DEPTH(2), .INV_MASK(MA)) dut_a (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data[7:0]),
        .in_ready(a_rdy), .out_valid(a_ov), .out_data(a_od), .out_ready(out_ready), .occupancy(a_occ));
    mbuf_pipe #(.WIDTH(8), .DEPTH(2), .INV_MASK(MB)) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data[7:0]),
        .in_ready(b_rdy), .out_valid(b_ov), .out_data(b_od), .out_ready(out_ready), .occupancy(b_occ));
    mbuf_pipe #(.WIDTH(16), .DEPTH(4), .INV_MASK(MC)) dut_c (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(c_rdy), .out_valid(c_ov), .out_data(c_od), .out_ready(out_ready), .occupancy(c_occ));

    logic rdy_o [3];
    logic ov_o [3];
    logic [15:0] od_o [3];
    logic [2:0] occ_o [3];
    assign rdy_o[0] = a_rdy;
    assign rdy_o[1] = b_rdy;
    assign rdy_o[2] = c_rdy;
    assign ov_o[0] = a_ov;
    assign ov_o[1] = b_ov;
    assign ov_o[2] = c_ov;
    assign od_o[0] = {8'h00, a_od};
    assign od_o[1] = {8'h00, b_od};
    assign od_o[2] = c_od;
    assign occ_o[0] = {1'b0, a_occ};
    assign occ_o[1] = {1'b0, b_occ};
    assign occ_o[2] = c_occ;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic int dep(input int i);
        return (i == 2) ? 4 : 2;
    endfunction

    function automatic logic [15:0] wm(input int i);
        return (i == 2) ? 16'hFFFF : 16'h00FF;
    endfunction

    // model: per configuration, DEPTH slots holding the raw accepted words; the output is the
    // raw word XOR the mask parity, words fall toward the exit one slot per cycle
    bit          mv [3][4];
    logic [15:0] md [3][4];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int  n, dd;
            bit  acc;
            logic [15:0] exp_d;
            dd = dep(i);
            n = 0;
            for (int k = 0; k < dd; k++) n += int'(mv[i][k]);
            exp_d = md[i][dd-1] ^ (PAR[i] ? wm(i) : 16'h0000);
            chk($sformatf("m%0d_out_valid", i), 32'(ov_o[i]), 32'(mv[i][dd-1]));
            chk($sformatf("m%0d_occupancy", i), 32'(occ_o[i]), 32'(n));
            chk($sformatf("m%0d_in_ready", i), 32'(rdy_o[i]),
                32'(!reset && !flush && (n < dd || out_ready)));
            if (mv[i][dd-1]) chk($sformatf("m%0d_out_data", i), 32'(od_o[i]), 32'(exp_d));
            if (reset || flush) begin
                for (int k = 0; k < 4; k++) mv[i][k] = 1'b0;
            end else begin
                acc = in_valid && (n < dd || out_ready);
                if (mv[i][dd-1] && out_ready) mv[i][dd-1] = 1'b0;
                for (int k = dd - 2; k >= 0; k--) begin
                    if (mv[i][k] && !mv[i][k+1]) begin
                        mv[i][k+1] = 1'b1;
                        md[i][k+1] = md[i][k];
                        mv[i][k] = 1'b0;
                    end
                end
                if (acc) begin
                    mv[i][0] = 1'b1;
                    md[i][0] = in_data & wm(i);
                end
            end
        end
    end

    task automatic drive(input logic r, input logic f, input logic iv, input logic [15:0] dat, input logic ordy);
        reset = r;
        flush = f;
        in_valid = iv;
        in_data = dat;
        out_ready = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 4; k++) begin
                mv[i][k] = 1'b0;
                md[i][k] = 16'h0000;
            end
        drive(1, 0, 0, 16'h0000, 0);
        tick();
        tick();
        chk("rst_in_ready", 32'(a_rdy), 0);
        chk("rst_out_valid", 32'(a_ov), 0);
        chk("rst_out_data", 32'(a_od), 0);
        chk("rst_occ", 32'(a_occ), 0);
        chk("rst_c_out_data", 32'(c_od), 0);

        // single word, no stall
        drive(0, 0, 1, 16'h005A, 1);
        chk("t1_in_ready", 32'(a_rdy), 1);
        tick();
        drive(0, 0, 0, 16'h0000, 1);
        chk("t1_occ_e1", 32'(a_occ), 1);
        chk("t1_ov_e1", 32'(a_ov), 0);
        tick();
        chk("t1_ov_e2", 32'(a_ov), 1);
        chk("t1_od_e2", 32'(a_od), 32'h5A);
        chk("t1_occ_e2", 32'(a_occ), 1);
        chk("t1_b_od_e2", 32'(b_od), 32'hA5);
        tick();
        chk("t1_occ_e3", 32'(a_occ), 0);
        chk("t1_ov_e3", 32'(a_ov), 0);
        repeat (4) tick();

        // inversion sweep on the single-inverting configuration
        drive(0, 0, 1, 16'h0000, 1);
        tick();
        drive(0, 0, 1, 16'h00FF, 1);
        tick();
        drive(0, 0, 0, 16'h0000, 1);
        chk("sweep_b_00", 32'(b_od), 32'hFF);
        tick();
        chk("sweep_b_ff", 32'(b_od), 32'h00);
        repeat (4) tick();

        // backpressure
        drive(0, 0, 1, 16'h0011, 0);
        tick();
        drive(0, 0, 1, 16'h0022, 0);
        tick();
        drive(0, 0, 1, 16'h0033, 0);
        chk("bp_full_ready", 32'(a_rdy), 0);
        tick();
        chk("bp_occ", 32'(a_occ), 2);
        chk("bp_ov", 32'(a_ov), 1);
        chk("bp_od", 32'(a_od), 32'h11);
        tick();
        chk("bp_hold", 32'(a_od), 32'h11);
        drive(0, 0, 1, 16'h0033, 1);
        chk("bp_pushpop_ready", 32'(a_rdy), 1);
        tick();
        drive(0, 0, 0, 16'h0000, 1);
        chk("bp_od_22", 32'(a_od), 32'h22);
        chk("bp_occ_pp", 32'(a_occ), 2);
        tick();
        chk("bp_od_33", 32'(a_od), 32'h33);
        chk("bp_occ_1", 32'(a_occ), 1);
        tick();
        chk("bp_empty", 32'(a_ov), 0);
        repeat (6) tick();

        // sustained streaming
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1, 16'(i), 1);
            tick();
            if (i > 0) begin
                chk($sformatf("st_ov_%0d", i), 32'(a_ov), 1);
                chk($sformatf("st_od_%0d", i), 32'(a_od), 32'(i - 1));
                chk($sformatf("st_occ_%0d", i), 32'(a_occ), 2);
            end
        end
        drive(0, 0, 0, 16'h0000, 1);
        tick();
        chk("st_last", 32'(a_od), 32'h09);
        chk("st_last_occ", 32'(a_occ), 1);
        repeat (5) tick();

        // flush with two words held
        drive(0, 0, 1, 16'h0044, 0);
        tick();
        drive(0, 0, 1, 16'h0055, 0);
        tick();
        chk("fl_occ_pre", 32'(a_occ), 2);
        drive(0, 1, 1, 16'h0077, 0);
        chk("fl_in_ready", 32'(a_rdy), 0);
        tick();
        drive(0, 0, 0, 16'h0000, 1);
        chk("fl_occ", 32'(a_occ), 0);
        chk("fl_ov", 32'(a_ov), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("fl_no77_%0d", i), 32'(a_ov), 0);
        end

        // mid-stream reset on the deep configuration
        drive(0, 0, 1, 16'h0001, 1);
        tick();
        drive(0, 0, 1, 16'h0002, 1);
        tick();
        drive(0, 0, 1, 16'h0003, 1);
        tick();
        chk("rs_c_occ_pre", 32'(c_occ), 3);
        drive(1, 0, 1, 16'h0004, 1);
        chk("rs_c_in_ready", 32'(c_rdy), 0);
        tick();
        drive(0, 0, 1, 16'hBEEF, 1);
        chk("rs_c_ov", 32'(c_ov), 0);
        chk("rs_c_od", 32'(c_od), 0);
        chk("rs_c_occ", 32'(c_occ), 0);
        tick();
        drive(0, 0, 0, 16'h0000, 1);
        tick();
        tick();
        chk("rs_c_e3", 32'(c_ov), 0);
        tick();
        chk("rs_c_e4_ov", 32'(c_ov), 1);
        chk("rs_c_e4_od", 32'(c_od), 32'h4110);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
